bts_st_packet_channel_arbiter: RTL and testbench

//  Round-robin packet arbiter merging NUM_IN Avalon-ST packet sources into one channelized stream.

---
 rtl/bts_st_packet_channel_arbiter.sv | 153 +++++++++++++++
 tb/tb_bts_st_packet_channel_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bts_st_packet_channel_arbiter.sv
// Round-robin Avalon-ST packet arbiter: merges NUM_IN sources into one channelized stream.
// Optional grant watchdog enabled by defining BTS_ARB_TIMEOUT_EN.
module bts_st_packet_channel_arbiter #(
  parameter int NUM_IN       = 4,
  parameter int DATA_W       = 8,
  parameter int CHANNEL_W    = 8,
  parameter int CHANNEL_BASE = 0
`ifdef BTS_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_IN-1:0]        in_valid,
  output logic [NUM_IN-1:0]        in_ready,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [NUM_IN-1:0]        in_startofpacket,
  input  logic [NUM_IN-1:0]        in_endofpacket,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket,
  output logic [CHANNEL_W-1:0]     out_channel
`ifdef BTS_ARB_TIMEOUT_EN
  , output logic                   err_timeout
`endif
);

  localparam int IDX_W = $clog2(NUM_IN);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

  logic [0:0]           state_r;
  logic [IDX_W-1:0]     grant_r;
  logic [IDX_W-1:0]     rr_ptr_r;
  logic [CHANNEL_W-1:0] chan_r;

  logic                 found_s;
  logic [IDX_W-1:0]     winner_s;
  logic [IDX_W-1:0]     rr_next_s;
  logic [CHANNEL_W-1:0] chan_s;
  logic                 out_space_s;
  logic                 accept_s;
  logic                 timeout_s;

  // Round-robin search: first requester at or after rr_ptr_r, wrapping.
  always_comb begin
    found_s  = 1'b0;
    winner_s = rr_ptr_r;
    for (int k = 0; k < NUM_IN; k++) begin
      int cand;
      cand = (int'(rr_ptr_r) + k) % NUM_IN;
      if (!found_s && in_valid[cand]) begin
        found_s  = 1'b1;
        winner_s = IDX_W'(cand);
      end else begin
        found_s = found_s;
      end
    end
    chan_s = CHANNEL_W'(CHANNEL_BASE + int'(winner_s));
  end

  // Handshake with the granted source and round-robin pointer advance.
  always_comb begin
    out_space_s = !out_valid || out_ready;
    in_ready    = {NUM_IN{1'b0}};
    if (reset_n && (state_r == ST_XFER)) begin
      in_ready[grant_r] = out_space_s;
    end else begin
      in_ready = {NUM_IN{1'b0}};
    end
    accept_s = (state_r == ST_XFER) && in_valid[grant_r] && out_space_s;
    if (grant_r == IDX_W'(NUM_IN - 1)) begin
      rr_next_s = {IDX_W{1'b0}};
    end else begin
      rr_next_s = grant_r + IDX_W'(1);
    end
  end

  // Grant FSM: the grant is only released by an accepted EOP (or the watchdog).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      grant_r  <= {IDX_W{1'b0}};
      rr_ptr_r <= {IDX_W{1'b0}};
      chan_r   <= {CHANNEL_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (found_s) begin
            grant_r <= winner_s;
            chan_r  <= chan_s;
            state_r <= ST_XFER;
          end
        end
        ST_XFER: begin
          if ((accept_s && in_endofpacket[grant_r]) || timeout_s) begin
            state_r  <= ST_IDLE;
            rr_ptr_r <= rr_next_s;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Output register: payload holds while the downstream stalls.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid         <= 1'b0;
      out_data          <= {DATA_W{1'b0}};
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      out_channel       <= {CHANNEL_W{1'b0}};
    end else if (accept_s) begin
      out_valid         <= 1'b1;
      out_data          <= in_data[grant_r*DATA_W +: DATA_W];
      out_startofpacket <= in_startofpacket[grant_r];
      out_endofpacket   <= in_endofpacket[grant_r];
      out_channel       <= chan_r;
    end else if (out_ready) begin
      out_valid         <= 1'b0;
    end
  end

`ifdef BTS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt_r;

  // The TIMEOUT_CYCLES-th consecutive idle cycle of the granted source fires.
  always_comb begin
    timeout_s = (state_r == ST_XFER) && !in_valid[grant_r] &&
                (to_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  // Stall counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      to_cnt_r    <= {CNT_W{1'b0}};
      err_timeout <= 1'b0;
    end else if ((state_r != ST_XFER) || accept_s || timeout_s) begin
      to_cnt_r    <= {CNT_W{1'b0}};
      err_timeout <= err_timeout | timeout_s;
    end else if (!in_valid[grant_r]) begin
      to_cnt_r    <= to_cnt_r + CNT_W'(1);
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

endmodule

// File: tb/tb_bts_st_packet_channel_arbiter.sv
// Directed self-checking bench for bts_st_packet_channel_arbiter (default 4-input build).
module tb_bts_st_packet_channel_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [31:0] in_data;
  logic [3:0]  in_sop;
  logic [3:0]  in_eop;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_sop;
  logic        out_eop;
  logic [7:0]  out_channel;
`ifdef BTS_ARB_TIMEOUT_EN
  logic        err_timeout;
`endif

  int checks = 0;
  int failures = 0;

  bts_st_packet_channel_arbiter dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .in_startofpacket  (in_sop),
    .in_endofpacket    (in_eop),
    .out_ready         (out_ready),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_startofpacket (out_sop),
    .out_endofpacket   (out_eop),
    .out_channel       (out_channel)
`ifdef BTS_ARB_TIMEOUT_EN
    , .err_timeout     (err_timeout)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] data, input logic [7:0] ch,
                         input logic sop, input logic eop);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_data"},  {24'd0, out_data}, {24'd0, data});
    chk({tag, "_chan"},  {24'd0, out_channel}, {24'd0, ch});
    chk({tag, "_sop"},   {31'd0, out_sop}, {31'd0, sop});
    chk({tag, "_eop"},   {31'd0, out_eop}, {31'd0, eop});
  endtask

  initial begin
    // Test 1: reset with every source requesting
    reset_n   = 1'b0;
    in_valid  = 4'hF;
    in_data   = 32'h13121110;
    in_sop    = 4'hF;
    in_eop    = 4'hF;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_out_sop", {31'd0, out_sop}, 32'd0);
    chk("rst_out_eop", {31'd0, out_eop}, 32'd0);
    chk("rst_out_chan", {24'd0, out_channel}, 32'd0);
    chk("rst_in_ready", {28'd0, in_ready}, 32'd0);

    // Test 3: round-robin over single-beat packets straight out of reset
    reset_n = 1'b1;
    for (int p = 0; p < 5; p++) begin
      tick();
      chk("rr_bubble_valid", {31'd0, out_valid}, 32'd0);
      chk("rr_grant_ready", {28'd0, in_ready}, 32'd1 << (p % 4));
      tick();
      chk_out("rr_beat", 8'h10 + 8'(p % 4), 8'(p % 4), 1'b1, 1'b1);
      chk("rr_after_ready", {28'd0, in_ready}, 32'd0);
    end
    in_valid = 4'h0;
    tick();
    chk("rr_drain", {31'd0, out_valid}, 32'd0);

    // Test 2: src2 three-beat packet (rr_ptr now 1, only src2 requests)
    in_sop = 4'h0;
    in_eop = 4'h0;
    in_valid = 4'b0100;
    in_data[23:16] = 8'hA1;
    in_sop[2] = 1'b1;
    tick();
    chk("s2_arb_ready", {28'd0, in_ready}, 32'h4);
    chk("s2_arb_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk_out("s2_b1", 8'hA1, 8'd2, 1'b1, 1'b0);
    in_data[23:16] = 8'hA2;
    in_sop[2] = 1'b0;
    tick();
    chk_out("s2_b2", 8'hA2, 8'd2, 1'b0, 1'b0);
    in_data[23:16] = 8'hA3;
    in_eop[2] = 1'b1;
    tick();
    chk_out("s2_b3", 8'hA3, 8'd2, 1'b0, 1'b1);
    in_valid = 4'h0;
    in_eop = 4'h0;
    tick();
    chk("s2_drain", {31'd0, out_valid}, 32'd0);

    // Test 4: src0 holds the grant while idle mid-packet; src1 waits (rr_ptr now 3)
    in_valid = 4'b0001;
    in_data[7:0] = 8'hB0;
    in_sop[0] = 1'b1;
    tick();
    tick();
    chk_out("lk_b0", 8'hB0, 8'd0, 1'b1, 1'b0);
    in_valid = 4'b0010;
    in_sop = 4'b0010;
    in_eop = 4'b0010;
    in_data[15:8] = 8'hC1;
    #1;
    chk("lk_hold_ready0", {28'd0, in_ready}, 32'h1);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("lk_no_beat", {31'd0, out_valid}, 32'd0);
      chk("lk_hold_ready", {28'd0, in_ready}, 32'h1);
    end
    in_valid = 4'b0011;
    in_data[7:0] = 8'hB1;
    in_eop[0] = 1'b1;
    tick();
    chk_out("lk_b1", 8'hB1, 8'd0, 1'b0, 1'b1);
    in_valid = 4'b0010;
    tick();
    chk("lk_src1_ready", {28'd0, in_ready}, 32'h2);
    tick();
    chk_out("lk_src1", 8'hC1, 8'd1, 1'b1, 1'b1);
    in_valid = 4'h0;
    in_sop = 4'h0;
    in_eop = 4'h0;
    tick();
    chk("lk_drain", {31'd0, out_valid}, 32'd0);

    // Test 5: backpressure mid-packet on src3 (rr_ptr now 2)
    in_valid = 4'b1000;
    in_data[31:24] = 8'hD0;
    in_sop[3] = 1'b1;
    tick();
    tick();
    chk_out("bp_d0", 8'hD0, 8'd3, 1'b1, 1'b0);
    in_data[31:24] = 8'hD1;
    in_sop[3] = 1'b0;
    tick();
    chk_out("bp_d1", 8'hD1, 8'd3, 1'b0, 1'b0);
    out_ready = 1'b0;
    in_data[31:24] = 8'hD2;
    #1;
    chk("bp_ready_off", {28'd0, in_ready}, 32'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_out("bp_hold", 8'hD1, 8'd3, 1'b0, 1'b0);
      chk("bp_stall_ready", {28'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_ready_on", {28'd0, in_ready}, 32'h8);
    tick();
    chk_out("bp_d2", 8'hD2, 8'd3, 1'b0, 1'b0);
    in_data[31:24] = 8'hD3;
    in_eop[3] = 1'b1;
    tick();
    chk_out("bp_d3", 8'hD3, 8'd3, 1'b0, 1'b1);
    in_valid = 4'h0;
    in_eop = 4'h0;
    tick();
    chk("bp_drain", {31'd0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
